target_spawner: RTL and testbench
=================================

# target_spawner

Parametrised multi-target generator for the VGA game datapath. It holds up to `NUM_BOXES` grid-aligned square targets and places each new one with an LFSR using rejection sampling, so placement is uniform, always on-screen and never overlaps another live target. It also produces the per-pixel overlay and hit index consumed by the VGA colour mux and game logic. It sits between the game-control FSM (spawn/clear requests) and the pixel pipeline (`x_pos`/`y_pos`).

## Interface
- `NUM_BOXES`, 4: number of target slots, 1..8.
- `BOX_SIZE`, 10: target edge in pixels; grid pitch.
- `H_ACTIVE`, 640: visible width in pixels; must be a multiple of `BOX_SIZE`.
- `V_ACTIVE`, 480: visible height in pixels; must be a multiple of `BOX_SIZE`.
- `LFSR_W`, 16: LFSR width; must be ≥ max(`COL_W`, `ROW_W`).
- `SEED`, 16'hACE1: LFSR reset value; 0 is replaced by 1.
- `MAX_TRIES`, 32: rejected draws allowed before a spawn fails.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `spawn_req` in 1: pulse; request placement into slot `spawn_idx`.
- `spawn_idx` in IDX_W: target slot, IDX_W = max(1, clog2(NUM_BOXES)).
- `clear_req` in 1: pulse; invalidate slot `clear_idx`.
- `clear_idx` in IDX_W: slot to clear.
- `x_pos` in 10: current pixel column.
- `y_pos` in 9: current pixel row.
- `spawn_busy` out 1: placement in progress.
- `spawn_done` out 1: one-cycle pulse at the end of a placement attempt.
- `spawn_fail` out 1: qualifies `spawn_done`; 1 means no free cell was found.
- `box_valid` out NUM_BOXES: per-slot live flag.
- `box_x_flat` out NUM_BOXES*10: slot i pixel x at bits [10i+9:10i].
- `box_y_flat` out NUM_BOXES*9: slot i pixel y at bits [9i+8:9i].
- `box_vga` out 1: current pixel lies inside any valid box.
- `box_hit_idx` out IDX_W: lowest-index valid box containing the pixel; 0 when `box_vga`=0.

## Operation
- Derived values: COLS=H_ACTIVE/BOX_SIZE, ROWS=V_ACTIVE/BOX_SIZE, COL_W=clog2(COLS), ROW_W=clog2(ROWS).
- LFSR: Galois, advances every cycle including while idle. Default taps are 0xB400 (x^16+x^14+x^13+x^11+1); the package holds a tap constant for each supported width.
- FSM states: IDLE, DRAW_X, DRAW_Y, CHECK.
  - IDLE: on `spawn_req`, latch `spawn_idx`, clear the try counter, go to DRAW_X. Otherwise stay.
  - DRAW_X: cand_col = lfsr[COL_W-1:0]. If cand_col ≥ COLS, reject (tries+1) and stay; otherwise go to DRAW_Y.
  - DRAW_Y: cand_row = lfsr[ROW_W-1:0]. If cand_row ≥ ROWS, reject (tries+1) and stay; otherwise go to CHECK.
  - CHECK: compare (cand_col, cand_row) against every valid slot except the latched one.
    - Collision: tries+1, go to DRAW_X.
    - No collision: write box_x = cand_col*BOX_SIZE and box_y = cand_row*BOX_SIZE, set `box_valid[idx]`=1, pulse `spawn_done`, go to IDLE.
  - In any draw state, a rejection that makes tries reach MAX_TRIES ends the attempt: `box_valid[idx]`=0, `spawn_done`=1 with `spawn_fail`=1, go to IDLE.
- Slot cells are stored as col/row; pixel coordinates are derived by constant multiply. No modulo anywhere.
- Overlay is combinational. A box contains the pixel when box_x ≤ x_pos < box_x+BOX_SIZE and box_y ≤ y_pos < box_y+BOX_SIZE. This gives a full BOX_SIZE×BOX_SIZE square.
- Respawning an already-valid slot is allowed. Its old cell is excluded from the collision check, and it stays visible at the old position until the write.

## Timing
- Reset values:
  - FSM in IDLE; lfsr=SEED.
  - All slot positions 0; `box_valid`=0.
  - `spawn_busy`, `spawn_done`, `spawn_fail` all 0.
  - Consequently `box_vga`=0 and `box_hit_idx`=0.
- `spawn_busy`=1 in every state except IDLE. `spawn_req` while busy is ignored (not queued).
- Best-case latency: request sampled at edge T; slot write and `spawn_done` visible after edge T+3. Each rejection adds 1 cycle.
- `spawn_done`/`spawn_fail` are registered and high for exactly one cycle. `spawn_fail` is 0 whenever `spawn_done`=0.
- `clear_req` takes effect at the next edge and is honoured in any FSM state.
- Clear and spawn-write to the same slot on the same edge: the write wins (slot becomes valid).
- `rst` mid-placement: FSM returns to IDLE, no `spawn_done` pulse, all slots invalid.
- `box_vga`/`box_hit_idx` have zero latency relative to `x_pos`/`y_pos`.

## Structure
- Package `target_spawner_pkg`: FSM state encoding, LFSR tap constants per width, default H/V active sizes.
- Sub-module `lfsr_galois` (parameters WIDTH, TAPS, SEED; ports clk, rst, q).
- Everything else in a single module: FSM, slot register array, overlay/priority encoder.

## Test plan
- Reset check: assert `rst` for 2 cycles. Require all outputs 0; internal lfsr = 16'hACE1.
- Default spawn: spawn idx 0. Require `spawn_done` within 3..3+MAX_TRIES cycles, `spawn_fail`=0, `box_valid`=4'b0001, box_x a multiple of 10 and < 640, box_y a multiple of 10 and < 480.
- Overlay edges: at the spawned (bx, by), pixels (bx, by) and (bx+9, by+9) give `box_vga`=1 with hit_idx 0; (bx+10, by) and (bx-1, by) give 0.
- Exhaustion: H_ACTIVE=20, V_ACTIVE=10, NUM_BOXES=3 (2 cells). Spawn 0 then 1 → distinct cells {(0,0),(10,0)}. Spawn 2 → `spawn_fail`=1 after MAX_TRIES rejections, `box_valid`=3'b011.
- Respawn and clear race: respawn slot 0 while slot 1 is valid → slot 0 never lands on slot 1's cell. Assert `clear_req` for idx 0 on the write edge → `box_valid[0]`=1.
- Busy and reset: a second `spawn_req` while busy → exactly one `spawn_done`. `rst` in DRAW_Y → no done pulse, `box_valid`=0.

Source files
------------

// File: rtl/target_spawner_pkg.sv
// Shared types and constants for the target spawner: FSM encoding, LFSR taps,
// default screen geometry.
package target_spawner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW_X = 2'd1,
        DRAW_Y = 2'd2,
        CHECK  = 2'd3
    } spawn_state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    // Right-shift Galois feedback masks for maximal-length sequences.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0E08;
            13:      return 32'h0000_1C80;
            14:      return 32'h0000_3802;
            15:      return 32'h0000_6000;
            default: return 32'h0000_B400;
        endcase
    endfunction

    // clog2 that never returns 0, so single-entry ranges still get a 1-bit field.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/target_spawner_lfsr.sv
// Free-running Galois LFSR; a zero seed would lock up, so it is forced to 1.
module lfsr_galois #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    always_ff @(posedge clk) begin
        if (rst) q <= SEED_EFF;
        else     q <= (q >> 1) ^ (q[0] ? TAPS : '0);
    end

endmodule

// File: rtl/target_spawner.sv
// Multi-slot target placer: rejection-sampled grid cells from an LFSR, no
// overlap between live slots, plus the combinational per-pixel overlay.
module target_spawner
    import target_spawner_pkg::*;
#(
    parameter int                NUM_BOXES = 4,
    parameter int                BOX_SIZE  = 10,
    parameter int                H_ACTIVE  = DEF_H_ACTIVE,
    parameter int                V_ACTIVE  = DEF_V_ACTIVE,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int                MAX_TRIES = 32,
    localparam int               IDX_W     = clog2_min1(NUM_BOXES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   spawn_req,
    input  logic [IDX_W-1:0]       spawn_idx,
    input  logic                   clear_req,
    input  logic [IDX_W-1:0]       clear_idx,
    input  logic [9:0]             x_pos,
    input  logic [8:0]             y_pos,
    output logic                   spawn_busy,
    output logic                   spawn_done,
    output logic                   spawn_fail,
    output logic [NUM_BOXES-1:0]   box_valid,
    output logic [NUM_BOXES*10-1:0] box_x_flat,
    output logic [NUM_BOXES*9-1:0] box_y_flat,
    output logic                   box_vga,
    output logic [IDX_W-1:0]       box_hit_idx
);

    localparam int COLS  = H_ACTIVE / BOX_SIZE;
    localparam int ROWS  = V_ACTIVE / BOX_SIZE;
    localparam int COL_W = clog2_min1(COLS);
    localparam int ROW_W = clog2_min1(ROWS);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    localparam logic [COL_W:0]   COLS_C  = COLS[COL_W:0];
    localparam logic [ROW_W:0]   ROWS_C  = ROWS[ROW_W:0];
    localparam logic [TRY_W-1:0] TRIES_C = MAX_TRIES[TRY_W-1:0];

    logic [LFSR_W-1:0] lfsr;
    logic              lfsr_unused;

    spawn_state_t      state, state_n;
    logic [IDX_W-1:0]  idx_q, idx_n;
    logic [TRY_W-1:0]  tries, tries_n, tries_inc;
    logic [COL_W-1:0]  cand_col, cand_col_n;
    logic [ROW_W-1:0]  cand_row, cand_row_n;
    logic              done_n, fail_n, wr_en, wr_ok, last_try, collide;

    logic [NUM_BOXES-1:0][COL_W-1:0] col_q;
    logic [NUM_BOXES-1:0][ROW_W-1:0] row_q;
    logic [NUM_BOXES-1:0]            in_box;

    lfsr_galois #(
        .WIDTH (LFSR_W),
        .TAPS  (LFSR_W'(lfsr_taps(LFSR_W))),
        .SEED  (SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    // Only the low bits feed the draws; the rest just keep the sequence long.
    assign lfsr_unused = ^lfsr;

    assign tries_inc  = tries + TRY_W'(1);
    assign last_try   = (tries_inc >= TRIES_C);
    assign spawn_busy = (state != IDLE);

    // The slot being (re)placed is excluded so a respawn may reuse its own cell.
    always_comb begin
        collide = 1'b0;
        for (int j = 0; j < NUM_BOXES; j++) begin
            if (idx_q != IDX_W'(j) && box_valid[j] &&
                col_q[j] == cand_col && row_q[j] == cand_row)
                collide = 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx_q;
        tries_n    = tries;
        cand_col_n = cand_col;
        cand_row_n = cand_row;
        done_n     = 1'b0;
        fail_n     = 1'b0;
        wr_en      = 1'b0;
        wr_ok      = 1'b0;
        case (state)
            IDLE: begin
                if (spawn_req) begin
                    idx_n   = spawn_idx;
                    tries_n = '0;
                    state_n = DRAW_X;
                end
            end
            DRAW_X: begin
                if ({1'b0, lfsr[COL_W-1:0]} >= COLS_C) begin
                    tries_n = tries_inc;
                    if (last_try) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        fail_n  = 1'b1;
                        wr_en   = 1'b1;
                    end
                end else begin
                    cand_col_n = lfsr[COL_W-1:0];
                    state_n    = DRAW_Y;
                end
            end
            DRAW_Y: begin
                if ({1'b0, lfsr[ROW_W-1:0]} >= ROWS_C) begin
                    tries_n = tries_inc;
                    if (last_try) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        fail_n  = 1'b1;
                        wr_en   = 1'b1;
                    end
                end else begin
                    cand_row_n = lfsr[ROW_W-1:0];
                    state_n    = CHECK;
                end
            end
            CHECK: begin
                // A collision also counts toward the budget, so a full board
                // whose draws never fall off-grid still terminates.
                if (collide) begin
                    tries_n = tries_inc;
                    if (last_try) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        fail_n  = 1'b1;
                        wr_en   = 1'b1;
                    end else begin
                        state_n = DRAW_X;
                    end
                end else begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    wr_en   = 1'b1;
                    wr_ok   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx_q      <= '0;
            tries      <= '0;
            cand_col   <= '0;
            cand_row   <= '0;
            spawn_done <= 1'b0;
            spawn_fail <= 1'b0;
        end else begin
            state      <= state_n;
            idx_q      <= idx_n;
            tries      <= tries_n;
            cand_col   <= cand_col_n;
            cand_row   <= cand_row_n;
            spawn_done <= done_n;
            spawn_fail <= fail_n;
        end
    end

    // Write is ordered after clear so a same-edge spawn write wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            box_valid <= '0;
            col_q     <= '0;
            row_q     <= '0;
        end else begin
            for (int i = 0; i < NUM_BOXES; i++) begin
                if (clear_req && clear_idx == IDX_W'(i))
                    box_valid[i] <= 1'b0;
                if (wr_en && idx_q == IDX_W'(i)) begin
                    box_valid[i] <= wr_ok;
                    if (wr_ok) begin
                        col_q[i] <= cand_col;
                        row_q[i] <= cand_row;
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_BOXES; i++) begin : g_slot
        logic [9:0]  bx;
        logic [8:0]  by;
        logic [10:0] x_lo, x_hi;
        logic [9:0]  y_lo, y_hi;

        assign bx   = 10'(col_q[i]) * 10'(BOX_SIZE);
        assign by   = 9'(row_q[i]) * 9'(BOX_SIZE);
        assign x_lo = {1'b0, bx};
        assign x_hi = x_lo + 11'(BOX_SIZE);
        assign y_lo = {1'b0, by};
        assign y_hi = y_lo + 10'(BOX_SIZE);

        assign box_x_flat[10*i +: 10] = bx;
        assign box_y_flat[9*i +: 9]   = by;
        assign in_box[i] = ({1'b0, x_pos} >= x_lo) && ({1'b0, x_pos} < x_hi) &&
                           ({1'b0, y_pos} >= y_lo) && ({1'b0, y_pos} < y_hi);
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        box_vga     = 1'b0;
        box_hit_idx = '0;
        for (int i = NUM_BOXES - 1; i >= 0; i--) begin
            if (box_valid[i] && in_box[i]) begin
                box_vga     = 1'b1;
                box_hit_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: tb/tb_target_spawner.sv
// Bench for target_spawner: directed corner sequences, an overlay vector table,
// and a randomized spawn/clear run checked against a slot-level model.
module tb_target_spawner;
    import target_spawner_pkg::*;

    localparam int N  = 4;
    localparam int MT = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance: default 640x480 geometry.
    logic        spawn_req, clear_req;
    logic [1:0]  spawn_idx, clear_idx;
    logic [9:0]  x_pos;
    logic [8:0]  y_pos;
    logic        spawn_busy, spawn_done, spawn_fail, box_vga;
    logic [N-1:0]    box_valid;
    logic [N*10-1:0] box_x_flat;
    logic [N*9-1:0]  box_y_flat;
    logic [1:0]      box_hit_idx;

    target_spawner #(.NUM_BOXES(N), .MAX_TRIES(MT)) dut (
        .clk(clk), .rst(rst),
        .spawn_req(spawn_req), .spawn_idx(spawn_idx),
        .clear_req(clear_req), .clear_idx(clear_idx),
        .x_pos(x_pos), .y_pos(y_pos),
        .spawn_busy(spawn_busy), .spawn_done(spawn_done), .spawn_fail(spawn_fail),
        .box_valid(box_valid), .box_x_flat(box_x_flat), .box_y_flat(box_y_flat),
        .box_vga(box_vga), .box_hit_idx(box_hit_idx)
    );

    // Tiny instance: 20x10 screen, only two cells, three slots.
    logic        s2_req, c2_req;
    logic [1:0]  s2_idx, c2_idx;
    logic [9:0]  x2;
    logic [8:0]  y2;
    logic        s2_busy, s2_done, s2_fail, s2_vga;
    logic [2:0]  s2_valid;
    logic [29:0] s2_xf;
    logic [26:0] s2_yf;
    logic [1:0]  s2_hit;

    target_spawner #(.NUM_BOXES(3), .H_ACTIVE(20), .V_ACTIVE(10), .MAX_TRIES(MT)) dut2 (
        .clk(clk), .rst(rst),
        .spawn_req(s2_req), .spawn_idx(s2_idx),
        .clear_req(c2_req), .clear_idx(c2_idx),
        .x_pos(x2), .y_pos(y2),
        .spawn_busy(s2_busy), .spawn_done(s2_done), .spawn_fail(s2_fail),
        .box_valid(s2_valid), .box_x_flat(s2_xf), .box_y_flat(s2_yf),
        .box_vga(s2_vga), .box_hit_idx(s2_hit)
    );

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    typedef struct {
        int   dx;
        int   dy;
        logic vga;
    } ov_vec_t;

    ov_vec_t ov_tab[8];

    // Slot-level reference state.
    bit mv[N];
    int mx[N];
    int my[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] galois_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // spawn_fail must never be seen without spawn_done, on either instance.
    always @(negedge clk) begin
        if (started) begin
            total++;
            if ((spawn_fail && !spawn_done) || (s2_fail && !s2_done)) begin
                bad++;
                $display("FAIL fail_qual: fail=%0b/%0b done=%0b/%0b", spawn_fail, s2_fail, spawn_done, s2_done);
            end
        end
    end

    task automatic spawn_main(input int idx, output int n, output logic done, output logic fail);
        spawn_idx = 2'(idx);
        spawn_req = 1'b1;
        tick();
        spawn_req = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!spawn_done && n < 200);
        done = spawn_done;
        fail = spawn_fail;
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic spawn_small(input int idx, output int n, output logic fail);
        s2_idx = 2'(idx);
        s2_req = 1'b1;
        tick();
        s2_req = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s2_done && n < 300);
        fail = s2_fail;
        chk("small_done_seen", 32'(s2_done), 32'd1);
    endtask

    function automatic logic [N-1:0] model_valid();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = mv[i];
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, bx, by, bx1, by1, cnt, xx, yy, exp_idx, k;
        logic d, f, exp_vga;

        ov_tab[0] = '{0, 0, 1'b1};
        ov_tab[1] = '{9, 9, 1'b1};
        ov_tab[2] = '{10, 0, 1'b0};
        ov_tab[3] = '{-1, 0, 1'b0};
        ov_tab[4] = '{9, 0, 1'b1};
        ov_tab[5] = '{0, 9, 1'b1};
        ov_tab[6] = '{0, 10, 1'b0};
        ov_tab[7] = '{0, -1, 1'b0};

        rst = 1'b1;
        spawn_req = 0; spawn_idx = 0; clear_req = 0; clear_idx = 0; x_pos = 0; y_pos = 0;
        s2_req = 0; s2_idx = 0; c2_req = 0; c2_idx = 0; x2 = 0; y2 = 0;

        // Reset state
        tick(); tick();
        started = 1'b1;
        chk("rst_busy", 32'(spawn_busy), 0);
        chk("rst_done", 32'(spawn_done), 0);
        chk("rst_fail", 32'(spawn_fail), 0);
        chk("rst_valid", 32'(box_valid), 0);
        chk("rst_x", box_x_flat, 0);
        chk("rst_y", box_y_flat, 0);
        chk("rst_vga", 32'(box_vga), 0);
        chk("rst_hit", 32'(box_hit_idx), 0);
        chk("rst_lfsr", 32'(dut.lfsr), 32'hACE1);
        rst = 1'b0;
        tick();
        chk("lfsr_step", 32'(dut.lfsr), 32'(galois_step(16'hACE1)));

        // Default spawn into slot 0
        spawn_main(0, n, d, f);
        chk("lat_range", 32'(n >= 3 && n <= 3 + MT), 1);
        chk("spawn0_fail", 32'(f), 0);
        chk("spawn0_valid", 32'(box_valid), 32'b0001);
        bx = int'(box_x_flat[9:0]);
        by = int'(box_y_flat[8:0]);
        chk("bx_grid", 32'(bx % 10 == 0 && bx < 640), 1);
        chk("by_grid", 32'(by % 10 == 0 && by < 480), 1);
        tick();
        chk("done_pulse", 32'(spawn_done), 0);

        // Overlay edge table
        for (int i = 0; i < 8; i++) begin
            xx = bx + ov_tab[i].dx;
            yy = by + ov_tab[i].dy;
            if (xx >= 0 && yy >= 0) begin
                x_pos = 10'(xx);
                y_pos = 9'(yy);
                #1;
                chk($sformatf("ov_vga_%0d", i), 32'(box_vga), 32'(ov_tab[i].vga));
                chk($sformatf("ov_hit_%0d", i), 32'(box_hit_idx), 0);
            end
        end

        // Exhaustion on the two-cell screen
        spawn_small(0, n, f);
        chk("ex_s0_fail", 32'(f), 0);
        spawn_small(1, n, f);
        chk("ex_s1_fail", 32'(f), 0);
        bx  = int'(s2_xf[9:0]);
        bx1 = int'(s2_xf[19:10]);
        chk("ex_cells", 32'(bx + bx1 == 10 && bx != bx1), 1);
        chk("ex_rows", 32'(s2_yf[17:0]), 0);
        spawn_small(2, n, f);
        chk("ex_s2_fail", 32'(f), 1);
        chk("ex_s2_lat", 32'(n >= MT), 1);
        chk("ex_valid", 32'(s2_valid), 32'b011);

        // Respawn slot 0 with slot 1 live, clear of slot 0 held through the write
        spawn_main(1, n, d, f);
        chk("rs_s1_fail", 32'(f), 0);
        bx1 = int'(box_x_flat[19:10]);
        by1 = int'(box_y_flat[17:9]);
        for (int r = 0; r < 4; r++) begin
            clear_idx = 2'd0;
            clear_req = 1'b1;
            spawn_idx = 2'd0;
            spawn_req = 1'b1;
            tick();
            spawn_req = 1'b0;
            chk("rs_clear_busy", 32'(box_valid[0]), 0);
            n = 0;
            do begin tick(); n++; end while (!spawn_done && n < 200);
            clear_req = 1'b0;
            chk("rs_done", 32'(spawn_done), 1);
            chk("rs_write_wins", 32'(box_valid[0]), 1);
            chk("rs_no_overlap", 32'(box_x_flat[9:0] == 10'(bx1) && box_y_flat[8:0] == 9'(by1)), 0);
        end

        // Second request while busy is dropped
        spawn_idx = 2'd2;
        spawn_req = 1'b1;
        tick();
        spawn_idx = 2'd3;
        tick();
        spawn_req = 1'b0;
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            if (spawn_done) cnt++;
            tick();
        end
        chk("busy_one_done", 32'(cnt), 1);
        chk("busy_valid", 32'(box_valid[3:2]), 32'b01);

        // Reset while in DRAW_Y
        spawn_idx = 2'd3;
        spawn_req = 1'b1;
        tick();
        spawn_req = 1'b0;
        n = 0;
        while (dut.state != DRAW_Y && n < 100) begin tick(); n++; end
        chk("reach_draw_y", 32'(dut.state == DRAW_Y), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 50; c++) begin
            if (spawn_done) cnt++;
            tick();
        end
        chk("rst_mid_done", 32'(cnt), 0);
        chk("rst_mid_valid", 32'(box_valid), 0);
        chk("rst_mid_busy", 32'(spawn_busy), 0);

        // Randomized spawn/clear run against the slot model
        for (int i = 0; i < N; i++) begin mv[i] = 0; mx[i] = 0; my[i] = 0; end
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, N - 1);
            if ($urandom_range(0, 2) != 2) begin
                spawn_main(k, n, d, f);
                chk("rnd_fail", 32'(f), 0);
                bx = int'(box_x_flat[10*k +: 10]);
                by = int'(box_y_flat[9*k +: 9]);
                chk("rnd_grid", 32'(bx % 10 == 0 && bx < 640 && by % 10 == 0 && by < 480), 1);
                for (int j = 0; j < N; j++)
                    if (j != k && mv[j])
                        chk("rnd_overlap", 32'(mx[j] == bx && my[j] == by), 0);
                mv[k] = 1; mx[k] = bx; my[k] = by;
            end else begin
                clear_idx = 2'(k);
                clear_req = 1'b1;
                tick();
                clear_req = 1'b0;
                mv[k] = 0;
            end
            chk("rnd_valid", 32'(box_valid), 32'(model_valid()));
            for (int p = 0; p < 3; p++) begin
                k = $urandom_range(0, N - 1);
                if (mv[k]) begin
                    xx = mx[k] + $urandom_range(0, 13) - 2;
                    yy = my[k] + $urandom_range(0, 13) - 2;
                end else begin
                    xx = $urandom_range(0, 639);
                    yy = $urandom_range(0, 479);
                end
                if (xx < 0) xx = 0;
                if (yy < 0) yy = 0;
                if (xx > 1023) xx = 1023;
                if (yy > 511) yy = 511;
                exp_vga = 1'b0;
                exp_idx = 0;
                for (int j = N - 1; j >= 0; j--)
                    if (mv[j] && xx >= mx[j] && xx < mx[j] + 10 && yy >= my[j] && yy < my[j] + 10) begin
                        exp_vga = 1'b1;
                        exp_idx = j;
                    end
                x_pos = 10'(xx);
                y_pos = 9'(yy);
                #1;
                chk("rnd_vga", 32'(box_vga), 32'(exp_vga));
                chk("rnd_hit", 32'(box_hit_idx), 32'(exp_idx));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
